data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Memory-side responder for data-cache line fills and dirty-line writebacks.
//  Accepts one block request at a time over a valid/ready handshake and models a fixed access latency.
//  Returns a full BLOCK_SIZE-word block on reads and commits a full block on writes.
//  Sits below data_cache in the memory hierarchy and replaces the zero-latency data_memory path.
// PARAMETERS
//  WORD_SIZE   32  bits per word
//  BLOCK_SIZE  16  words per block; line width = WORD_SIZE*BLOCK_SIZE
//  IDX_BITS    10  block-index width; memory depth = 2**IDX_BITS blocks
//  LATENCY     4   cycles from request accept edge to resp_valid rising; legal range >= 1
// PORTS
//  clk         in   1                     rising-edge clock
//  rst_n       in   1                     asynchronous active-low reset
//  req_valid   in   1                     request present
//  req_ready   out  1                     controller can accept a request
//  req_write   in   1                     1 = writeback, 0 = line fill
//  req_addr    in   WORD_SIZE             word address; [3:0] ignored, block index = [4 +: IDX_BITS]
//  req_block   in   WORD_SIZE*BLOCK_SIZE  writeback data; word 0 occupies the MSBs
//  resp_valid  out  1                     response present
//  resp_ready  in   1                     cache accepts the response
//  resp_block  out  WORD_SIZE*BLOCK_SIZE  fill data for reads; all zero for writes and errors
//  resp_write  out  1                     echo of req_write for the current response
//  resp_err    out  1                     address out of range; no array access was performed
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_block=0, resp_write=0, resp_err=0, latency counter=0.
//  - The array is not cleared by reset; its contents persist across reset.
//  - Reset asserted mid-operation aborts the request. A pending write is discarded if its commit edge has not yet occurred.
//  - FSM states: IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready=1. On a clock edge with req_valid=1:
//      - latch req_addr, req_write and req_block;
//      - load the counter with LATENCY-1;
//      - go to WAIT; req_ready=0 from the next cycle.
//  - WAIT: req_ready=0 and req_* are ignored. The counter decrements each cycle; at count 0, take the access edge:
//      - in range, write: array[idx] <= latched block.
//      - in range, read: resp_block <= array[idx].
//      - out of range (any req_addr bit above 4+IDX_BITS-1 set): resp_err=1, array untouched, resp_block=0.
//      - In all cases: resp_valid=1, resp_write=latched write, go to RESP.
//  - Timing: resp_valid is first high exactly LATENCY cycles after the accept edge.
//  - RESP: hold resp_valid, resp_block, resp_write and resp_err stable until resp_ready=1.
//      - On the handshake edge: resp_valid=0, resp_err=0, resp_block=0, go to IDLE; req_ready=1 the following cycle.
//  - Requests cannot overlap. At most one request is outstanding; a request is never accepted on the response-handshake edge.
//  - Read-after-write to the same block in consecutive transactions returns the written data.
//  - Word ordering: word w of a block is at bits [WORD_SIZE*(BLOCK_SIZE-w)-1 -: WORD_SIZE], matching the data_cache line layout.
//  - Minimum turnaround per transaction: LATENCY+2 cycles when resp_ready is held high.
// TESTING
//  - Reset: after rst_n low -> req_ready=1, resp_valid=0, resp_block=0, resp_err=0; rst_n high -> unchanged.
//  - Writeback then fill:
//      - write block 0x0000_0010, word w = 0x1000+w -> resp_valid exactly 4 cycles after accept, resp_write=1, resp_block=0;
//      - then read 0x0000_001C -> resp_block word 0 = 0x1000, word 15 = 0x100F, resp_write=0.
//  - Backpressure: hold resp_ready=0 for 6 cycles -> resp_valid and resp_block stable throughout, req_ready=0;
//      release -> IDLE, req_ready=1 one cycle later.
//  - Out of range: read addr 0x0001_4000 (IDX_BITS=10) -> resp_err=1, resp_block=0; a following read of block 0 returns its prior contents.
//  - Reset mid-WAIT: write block 5, assert rst_n=0 two cycles after accept -> outputs at reset values; later read of block 5 returns its old data.
//  - Ignored requests: req_valid toggling during WAIT/RESP with other addresses -> no extra responses; the next accept happens only in IDLE.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Cache-to-memory block transfer bus: one request channel and one response channel,
// each with a valid/ready handshake. The master is the cache, the slave is the memory controller.
interface data_memory_ctrl_if #(
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned BLOCK_SIZE = 16
);
   localparam int unsigned LINE_BITS = WORD_SIZE * BLOCK_SIZE;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [WORD_SIZE-1:0] req_addr;
   logic [LINE_BITS-1:0] req_block;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [LINE_BITS-1:0] resp_block;
   logic                 resp_write;
   logic                 resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_block, resp_ready,
      input  req_ready, resp_valid, resp_block, resp_write, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_block, resp_ready,
      output req_ready, resp_valid, resp_block, resp_write, resp_err
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Memory-side responder for data-cache line fills and dirty-line writebacks.
// One block request at a time, fixed access latency, full-block reads and writes.
// Array contents are not touched by reset.
module data_memory_ctrl #(
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned BLOCK_SIZE = 16,
   parameter int unsigned IDX_BITS   = 10,
   parameter int unsigned LATENCY    = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   data_memory_ctrl_if.slave   bus
);
   localparam int unsigned LINE_BITS = WORD_SIZE * BLOCK_SIZE;
   localparam int unsigned DEPTH     = 2 ** IDX_BITS;
   localparam int unsigned IDX_LSB   = 4;
   localparam int unsigned HI_LSB    = IDX_LSB + IDX_BITS;
   localparam int unsigned CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic                  write_q;
   logic                  oor_q;
   logic [IDX_BITS-1:0]   idx_q;
   logic [LINE_BITS-1:0]  blk_q;

   logic                  req_ready;
   logic                  resp_valid;
   logic [LINE_BITS-1:0]  resp_block;
   logic                  resp_write;
   logic                  resp_err;

   logic                  req_oor;
   logic                  commit;
   logic                  unused_addr_bits;

   logic [LINE_BITS-1:0]  mem [DEPTH];

   assign bus.req_ready  = req_ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_block = resp_block;
   assign bus.resp_write = resp_write;
   assign bus.resp_err   = resp_err;

   // Word-offset bits select nothing inside a block transfer.
   assign unused_addr_bits = ^bus.req_addr[IDX_LSB-1:0];

   // Any address bit above the block index marks the request out of range.
   always_comb begin
      req_oor = |(bus.req_addr >> HI_LSB);
   end

   // Write strobe for the access edge; a reset mid-WAIT forces IDLE so the write is dropped.
   always_comb begin
      commit = (state == WAIT) && (cnt == '0) && write_q && !oor_q;
   end

   // Block array: written only on a committed in-range writeback.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem[idx_q] <= blk_q;
      end
   end

   // Request/response FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         write_q    <= 1'b0;
         oor_q      <= 1'b0;
         idx_q      <= '0;
         blk_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_block <= '0;
         resp_write <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  write_q   <= bus.req_write;
                  oor_q     <= req_oor;
                  idx_q     <= bus.req_addr[IDX_LSB +: IDX_BITS];
                  blk_q     <= bus.req_block;
                  cnt       <= CW'(LATENCY - 1);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  resp_valid <= 1'b1;
                  resp_write <= write_q;
                  if (oor_q) begin
                     resp_err   <= 1'b1;
                     resp_block <= '0;
                  end else if (!write_q) begin
                     resp_block <= mem[idx_q];
                  end else begin
                     resp_block <= '0;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_block <= '0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (WORD_SIZE=32, BLOCK_SIZE=16, IDX_BITS=10, LATENCY=4).
module tb_data_memory_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   data_memory_ctrl_if #(.WORD_SIZE(32), .BLOCK_SIZE(16)) bus ();

   data_memory_ctrl #(
      .WORD_SIZE (32),
      .BLOCK_SIZE(16),
      .IDX_BITS  (10),
      .LATENCY   (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] mk(input logic [31:0] base);
      logic [511:0] b;
      b = '0;
      for (int w = 0; w < 16; w++) begin
         b[32*(16-w)-1 -: 32] = base + 32'(w);
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request from IDLE and releases req_valid after the accept edge.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [511:0] blk);
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_block = blk;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      chk("accept_ready_low", {511'b0, bus.req_ready}, 512'd0);
   endtask

   // Bounded wait for resp_valid; checks the number of cycles since the accept edge.
   task automatic wait_resp(input string tag);
      int n;
      n = 0;
      while (!bus.resp_valid && n < 20) begin
         step();
         n++;
      end
      chk(tag, 512'(n), 512'd4);
   endtask

   task automatic finish_resp(input string tag);
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      chk({tag, "_valid_clr"}, {511'b0, bus.resp_valid}, 512'd0);
      chk({tag, "_ready_set"}, {511'b0, bus.req_ready}, 512'd1);
      chk({tag, "_block_clr"}, bus.resp_block, 512'd0);
      chk({tag, "_err_clr"},   {511'b0, bus.resp_err}, 512'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [511:0] blk_a, blk_b, blk_c, blk_d, blk_e, junk;
      blk_a = mk(32'h0000_1000);
      blk_b = mk(32'h0000_B000);
      blk_c = mk(32'h0000_C000);
      blk_d = mk(32'h0000_D000);
      blk_e = mk(32'h0000_E000);
      junk  = mk(32'hDEAD_0000);

      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_block  = '0;
      bus.resp_ready = 1'b0;
      rst_n          = 1'b0;
      step();
      step();
      chk("rst_req_ready",  {511'b0, bus.req_ready},  512'd1);
      chk("rst_resp_valid", {511'b0, bus.resp_valid}, 512'd0);
      chk("rst_resp_block", bus.resp_block,           512'd0);
      chk("rst_resp_err",   {511'b0, bus.resp_err},   512'd0);
      chk("rst_resp_write", {511'b0, bus.resp_write}, 512'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_req_ready",  {511'b0, bus.req_ready},  512'd1);
      chk("post_rst_resp_valid", {511'b0, bus.resp_valid}, 512'd0);

      // Writeback block 1 (addr 0x10), then fill from 0x1C (same block).
      issue(1'b1, 32'h0000_0010, blk_a);
      wait_resp("wr1_latency");
      chk("wr1_resp_write", {511'b0, bus.resp_write}, 512'd1);
      chk("wr1_resp_block", bus.resp_block,           512'd0);
      chk("wr1_resp_err",   {511'b0, bus.resp_err},   512'd0);
      finish_resp("wr1");

      issue(1'b0, 32'h0000_001C, blk_e);
      wait_resp("rd1_latency");
      chk("rd1_word0",      {480'b0, bus.resp_block[511 -: 32]}, {480'b0, 32'h0000_1000});
      chk("rd1_word15",     {480'b0, bus.resp_block[31:0]},      {480'b0, 32'h0000_100F});
      chk("rd1_block",      bus.resp_block,                      blk_a);
      chk("rd1_resp_write", {511'b0, bus.resp_write},            512'd0);
      // Backpressure for six cycles with stray requests that must be ignored.
      for (int i = 0; i < 6; i++) begin
         bus.req_valid = i[0];
         bus.req_addr  = 32'h0000_0050;
         bus.req_write = 1'b1;
         bus.req_block = junk;
         step();
         chk("bp_valid", {511'b0, bus.resp_valid}, 512'd1);
         chk("bp_block", bus.resp_block,           blk_a);
         chk("bp_ready", {511'b0, bus.req_ready},  512'd0);
      end
      bus.req_valid = 1'b0;
      finish_resp("rd1");

      // Seed blocks 3, 0 and 5 with known data.
      issue(1'b1, 32'h0000_0030, blk_c);
      wait_resp("seed3_latency");
      finish_resp("seed3");
      issue(1'b1, 32'h0000_0000, blk_b);
      wait_resp("seed0_latency");
      finish_resp("seed0");
      issue(1'b1, 32'h0000_0050, blk_d);
      wait_resp("seed5_latency");
      finish_resp("seed5");

      // Ignored requests: req_valid held high at block 3 through WAIT, RESP and the handshake edge.
      issue(1'b0, 32'h0000_0040, junk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0000_0030;
      bus.req_block = junk;
      wait_resp("ign_latency");
      step();
      step();
      chk("ign_resp_write", {511'b0, bus.resp_write}, 512'd0);
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b0;
      chk("ign_no_accept_on_handshake", {511'b0, bus.req_ready}, 512'd1);
      for (int i = 0; i < 6; i++) step();
      chk("ign_no_extra_resp", {511'b0, bus.resp_valid}, 512'd0);
      issue(1'b0, 32'h0000_0030, junk);
      wait_resp("rd3_latency");
      chk("rd3_block", bus.resp_block, blk_c);
      finish_resp("rd3");

      // Out of range: read and write to 0x0001_4000 (index bits alias block 0).
      issue(1'b0, 32'h0001_4000, junk);
      wait_resp("oor_rd_latency");
      chk("oor_rd_err",   {511'b0, bus.resp_err}, 512'd1);
      chk("oor_rd_block", bus.resp_block,         512'd0);
      finish_resp("oor_rd");
      issue(1'b1, 32'h0001_4000, junk);
      wait_resp("oor_wr_latency");
      chk("oor_wr_err",   {511'b0, bus.resp_err},   512'd1);
      chk("oor_wr_write", {511'b0, bus.resp_write}, 512'd1);
      finish_resp("oor_wr");
      issue(1'b0, 32'h0000_0000, junk);
      wait_resp("rd0_latency");
      chk("rd0_block", bus.resp_block,         blk_b);
      chk("rd0_err",   {511'b0, bus.resp_err}, 512'd0);
      finish_resp("rd0");

      // Reset two cycles after accepting a write to block 5.
      issue(1'b1, 32'h0000_0050, blk_e);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready",  {511'b0, bus.req_ready},  512'd1);
      chk("midrst_resp_valid", {511'b0, bus.resp_valid}, 512'd0);
      chk("midrst_resp_block", bus.resp_block,           512'd0);
      chk("midrst_resp_err",   {511'b0, bus.resp_err},   512'd0);
      step();
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("midrst_idle_valid", {511'b0, bus.resp_valid}, 512'd0);
      issue(1'b0, 32'h0000_0050, junk);
      wait_resp("rd5_latency");
      chk("rd5_block", bus.resp_block, blk_d);
      finish_resp("rd5");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
